fpu_issue_ctrl: RTL and testbench

Front-end issue and result-collection stage for the three-stage FPU. It accepts operations from the core over a valid/ready handshake and drives the FPU operand, frm and funct7 inputs. Because the FPU pipeline cannot stall, the block tracks in-flight operations in a tag/valid shift pipe matched to FPU latency. Results are captured in order into a response FIFO, and the RISC-V sticky fflags are accumulated here.

---
 rtl/fpu_issue_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_fpu_issue_ctrl.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_issue_ctrl.sv
// Issue and result-collection stage for the three-stage FPU: in-order response FIFO, sticky fflags.
// Define FPU_ISSUE_PERF_EN to add saturating perf_ops / perf_stall counters.
module fpu_issue_ctrl #(
  parameter int LATENCY    = 2,
  parameter int RESP_DEPTH = 4,
  parameter int TAG_W      = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_fp1,
  input  logic [31:0]      req_fp2,
  input  logic [2:0]       req_frm,
  input  logic [6:0]       req_funct7,
  input  logic [TAG_W-1:0] req_tag,
  output logic [31:0]      fpu_fp1,
  output logic [31:0]      fpu_fp2,
  output logic [2:0]       fpu_frm,
  output logic [6:0]       fpu_funct7,
  input  logic [31:0]      fpu_result,
  input  logic [4:0]       fpu_flags,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [31:0]      resp_result,
  output logic [4:0]       resp_flags,
  output logic [TAG_W-1:0] resp_tag,
  input  logic             flush,
  input  logic             fflags_clr,
  output logic [4:0]       fflags,
  output logic             busy
`ifdef FPU_ISSUE_PERF_EN
  ,
  output logic [31:0]      perf_ops,
  output logic [31:0]      perf_stall
`endif
);

  localparam logic [6:0] F7_ADD = 7'b0100000;
  localparam logic [6:0] F7_SUB = 7'b0100100;
  localparam logic [6:0] F7_MUL = 7'b0000010;
  localparam int PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int CNT_W = $clog2(RESP_DEPTH + 1);
  localparam int OCC_W = $clog2(LATENCY + RESP_DEPTH + 1);

  typedef struct packed {
    logic [31:0]      result;
    logic [4:0]       flags;
    logic [TAG_W-1:0] tag;
  } resp_t;

  logic [LATENCY-1:0] pipe_vld_q, pipe_vld_d;
  logic [LATENCY-1:0] pipe_unsup_q, pipe_unsup_d;
  logic [TAG_W-1:0]   pipe_tag_q [LATENCY];
  logic [TAG_W-1:0]   pipe_tag_d [LATENCY];
  logic [31:0]        hold_fp1_q, hold_fp1_d, hold_fp2_q, hold_fp2_d;
  logic [2:0]         hold_frm_q, hold_frm_d;
  logic [6:0]         hold_f7_q, hold_f7_d;
  resp_t              fifo_q [RESP_DEPTH];
  resp_t              fifo_d [RESP_DEPTH];
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [4:0]         fflags_q, fflags_d;
  logic [OCC_W-1:0]   occ;
  logic               accept, supported, push, pop;
  resp_t              cap;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RESP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Ops in the pipe count against the FIFO so a capture can never overflow it
  always_comb begin
    occ = OCC_W'(cnt_q);
    for (int i = 0; i < LATENCY; i++) begin
      occ = occ + OCC_W'(pipe_vld_q[i]);
    end
  end

  assign req_ready  = !rst && !flush && (occ < OCC_W'(RESP_DEPTH));
  assign accept     = req_valid && req_ready;
  assign supported  = (req_funct7 == F7_ADD) || (req_funct7 == F7_SUB) || (req_funct7 == F7_MUL);
  assign fpu_fp1    = (accept && supported) ? req_fp1    : hold_fp1_q;
  assign fpu_fp2    = (accept && supported) ? req_fp2    : hold_fp2_q;
  assign fpu_frm    = (accept && supported) ? req_frm    : hold_frm_q;
  assign fpu_funct7 = (accept && supported) ? req_funct7 : hold_f7_q;

  always_comb begin
    hold_fp1_d = hold_fp1_q;
    hold_fp2_d = hold_fp2_q;
    hold_frm_d = hold_frm_q;
    hold_f7_d  = hold_f7_q;
    if (accept && supported) begin
      hold_fp1_d = req_fp1;
      hold_fp2_d = req_fp2;
      hold_frm_d = req_frm;
      hold_f7_d  = req_funct7;
    end
  end

  always_comb begin
    pipe_vld_d      = '0;
    pipe_unsup_d    = '0;
    pipe_tag_d      = pipe_tag_q;
    pipe_vld_d[0]   = accept;
    pipe_unsup_d[0] = !supported;
    pipe_tag_d[0]   = req_tag;
    for (int i = 1; i < LATENCY; i++) begin
      pipe_vld_d[i]   = pipe_vld_q[i-1] && !flush;
      pipe_unsup_d[i] = pipe_unsup_q[i-1];
      pipe_tag_d[i]   = pipe_tag_q[i-1];
    end
  end

  // Unsupported ops return a canonical NaN with NV; FPU flags are reordered into fflags layout
  always_comb begin
    cap.tag = pipe_tag_q[LATENCY-1];
    if (pipe_unsup_q[LATENCY-1]) begin
      cap.result = 32'h7FC00000;
      cap.flags  = 5'b10000;
    end else begin
      cap.result = fpu_result;
      cap.flags  = {fpu_flags[0], fpu_flags[2], fpu_flags[4], fpu_flags[3], fpu_flags[1]};
    end
  end

  assign push        = pipe_vld_q[LATENCY-1] && !flush;
  assign resp_valid  = (cnt_q != '0);
  assign pop         = resp_valid && resp_ready;
  assign resp_result = resp_valid ? fifo_q[rd_ptr_q].result : '0;
  assign resp_flags  = resp_valid ? fifo_q[rd_ptr_q].flags  : '0;
  assign resp_tag    = resp_valid ? fifo_q[rd_ptr_q].tag    : '0;
  assign busy        = (occ != '0);
  assign fflags      = fflags_q;

  always_comb begin
    fifo_d   = fifo_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (push) begin
      fifo_d[wr_ptr_q] = cap;
      wr_ptr_d         = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
    if (flush) begin
      cnt_d    = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end
    fflags_d = (fflags_clr ? 5'b0 : fflags_q) | (pop ? resp_flags : 5'b0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_vld_q   <= '0;
      pipe_unsup_q <= '0;
      for (int i = 0; i < LATENCY; i++) pipe_tag_q[i] <= '0;
      for (int i = 0; i < RESP_DEPTH; i++) fifo_q[i] <= '0;
      hold_fp1_q   <= '0;
      hold_fp2_q   <= '0;
      hold_frm_q   <= '0;
      hold_f7_q    <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      cnt_q        <= '0;
      fflags_q     <= '0;
    end else begin
      pipe_vld_q   <= pipe_vld_d;
      pipe_unsup_q <= pipe_unsup_d;
      pipe_tag_q   <= pipe_tag_d;
      fifo_q       <= fifo_d;
      hold_fp1_q   <= hold_fp1_d;
      hold_fp2_q   <= hold_fp2_d;
      hold_frm_q   <= hold_frm_d;
      hold_f7_q    <= hold_f7_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      cnt_q        <= cnt_d;
      fflags_q     <= fflags_d;
    end
  end

`ifdef FPU_ISSUE_PERF_EN
  logic [31:0] perf_ops_q, perf_ops_d, perf_stall_q, perf_stall_d;

  always_comb begin
    perf_ops_d   = perf_ops_q;
    perf_stall_d = perf_stall_q;
    if (accept && (perf_ops_q != 32'hFFFFFFFF)) perf_ops_d = perf_ops_q + 32'd1;
    if (req_valid && !req_ready && (perf_stall_q != 32'hFFFFFFFF)) perf_stall_d = perf_stall_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_ops_q   <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_ops_q   <= perf_ops_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_ops   = perf_ops_q;
  assign perf_stall = perf_stall_q;
`endif

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Bench for fpu_issue_ctrl: directed vector table, hand sequences and random traffic against a queue model.
module tb_fpu_issue_ctrl;

  localparam int LAT   = 2;
  localparam int DEPTH = 4;
  localparam int TW    = 5;
  localparam logic [6:0] ADD = 7'b0100000;
  localparam logic [6:0] SUB = 7'b0100100;
  localparam logic [6:0] MUL = 7'b0000010;
  localparam logic [6:0] UNS = 7'b0101100;

  logic          clk, rst;
  logic          req_valid, req_ready;
  logic [31:0]   req_fp1, req_fp2;
  logic [2:0]    req_frm;
  logic [6:0]    req_funct7;
  logic [TW-1:0] req_tag;
  logic [31:0]   fpu_fp1, fpu_fp2;
  logic [2:0]    fpu_frm;
  logic [6:0]    fpu_funct7;
  logic [31:0]   fpu_result;
  logic [4:0]    fpu_flags;
  logic          resp_valid, resp_ready;
  logic [31:0]   resp_result;
  logic [4:0]    resp_flags;
  logic [TW-1:0] resp_tag;
  logic          flush, fflags_clr;
  logic [4:0]    fflags;
  logic          busy;
`ifdef FPU_ISSUE_PERF_EN
  logic [31:0]   perf_ops, perf_stall;
  logic [31:0]   mOps, mStall;
`endif

  fpu_issue_ctrl #(.LATENCY(LAT), .RESP_DEPTH(DEPTH), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_fp1(req_fp1), .req_fp2(req_fp2), .req_frm(req_frm),
    .req_funct7(req_funct7), .req_tag(req_tag),
    .fpu_fp1(fpu_fp1), .fpu_fp2(fpu_fp2), .fpu_frm(fpu_frm), .fpu_funct7(fpu_funct7),
    .fpu_result(fpu_result), .fpu_flags(fpu_flags),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_result(resp_result), .resp_flags(resp_flags), .resp_tag(resp_tag),
    .flush(flush), .fflags_clr(fflags_clr), .fflags(fflags), .busy(busy)
`ifdef FPU_ISSUE_PERF_EN
    , .perf_ops(perf_ops), .perf_stall(perf_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in FPU: {flags in FPU order {ovf,unf,dz,nx,nv}, result}; real values for the directed cases
  function automatic logic [36:0] fpuModel(input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b);
    if (f7 == ADD && a == 32'h3F800000 && b == 32'h40000000) return {5'b00000, 32'h40400000};
    if (f7 == MUL && a == 32'h40000000 && b == 32'h40400000) return {5'b00000, 32'h40C00000};
    if (f7 == ADD && a == 32'h7F800000 && b == 32'hFF800000) return {5'b00001, 32'h7FC00000};
    return {a[4:0] ^ b[9:5], a + b + {25'b0, f7}};
  endfunction

  function automatic logic [4:0] toFflags(input logic [4:0] f);
    logic ovf, unf, dz, nx, nv;
    {ovf, unf, dz, nx, nv} = f;
    return {nv, dz, ovf, unf, nx};
  endfunction

  function automatic logic isSupported(input logic [6:0] f7);
    return (f7 == ADD) || (f7 == SUB) || (f7 == MUL);
  endfunction

  logic [36:0] fpuPipe [LAT];
  always_ff @(posedge clk) begin
    fpuPipe[0] <= fpuModel(fpu_funct7, fpu_fp1, fpu_fp2);
    for (int i = 1; i < LAT; i++) fpuPipe[i] <= fpuPipe[i-1];
  end
  assign fpu_result = fpuPipe[LAT-1][31:0];
  assign fpu_flags  = fpuPipe[LAT-1][36:32];

  typedef struct packed {
    int            due;
    logic [31:0]   res;
    logic [4:0]    fl;
    logic [TW-1:0] tag;
  } ent_t;

  typedef struct {
    logic v; logic [6:0] f7; logic [31:0] a; logic [31:0] b; logic [TW-1:0] tag;
    logic rr; logic fl; logic clr;
    logic eReady; logic eRv; logic [31:0] eRes; logic [4:0] eFl; logic [TW-1:0] eTag;
    logic [4:0] eFf; logic eBusy; logic [6:0] eF7;
  } vec_t;

  ent_t          inflight[$];
  ent_t          fifoQ[$];
  vec_t          vecs[$];
  logic [TW-1:0] popTags[$];
  logic [31:0]   popRes[$];
  logic [4:0]    mFflags;
  logic [31:0]   lastFp1, lastFp2;
  logic [2:0]    lastFrm;
  logic [6:0]    lastF7;
  int            cyc, total, bad, dutAccepts;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic addRow(input logic v, input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b,
                        input logic [TW-1:0] tag, input logic clr, input logic eReady, input logic eRv,
                        input logic [31:0] eRes, input logic [4:0] eFl, input logic [TW-1:0] eTag,
                        input logic [4:0] eFf, input logic eBusy, input logic [6:0] eF7);
    vec_t r;
    r.v = v; r.f7 = f7; r.a = a; r.b = b; r.tag = tag; r.rr = 1'b1; r.fl = 1'b0; r.clr = clr;
    r.eReady = eReady; r.eRv = eRv; r.eRes = eRes; r.eFl = eFl; r.eTag = eTag;
    r.eFf = eFf; r.eBusy = eBusy; r.eF7 = eF7;
    vecs.push_back(r);
  endtask

  task automatic applyStimulus(input logic v, input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b,
                               input logic [2:0] frm, input logic [TW-1:0] tag,
                               input logic rr, input logic fl, input logic clr);
    @(negedge clk);
    req_valid = v; req_funct7 = f7; req_fp1 = a; req_fp2 = b; req_frm = frm; req_tag = tag;
    resp_ready = rr; flush = fl; fflags_clr = clr;
    #1;
  endtask

  // Compare this cycle's outputs to the model, then advance the model across the coming edge
  task automatic checkOutput();
    int occ;
    logic expReady, acc, sup;
    ent_t e;
    logic [36:0] r;
    occ      = inflight.size() + fifoQ.size();
    expReady = !flush && (occ < DEPTH);
    check("req_ready", req_ready, expReady);
    check("busy", busy, occ != 0);
    check("resp_valid", resp_valid, fifoQ.size() != 0);
    if (fifoQ.size() != 0) begin
      check("resp_result", resp_result, fifoQ[0].res);
      check("resp_flags", resp_flags, fifoQ[0].fl);
      check("resp_tag", resp_tag, fifoQ[0].tag);
    end
    check("fflags", fflags, mFflags);
    acc = req_valid && expReady;
    sup = isSupported(req_funct7);
    if (acc && sup) begin
      lastFp1 = req_fp1; lastFp2 = req_fp2; lastFrm = req_frm; lastF7 = req_funct7;
    end
    check("fpu_fp1", fpu_fp1, lastFp1);
    check("fpu_fp2", fpu_fp2, lastFp2);
    check("fpu_frm", fpu_frm, lastFrm);
    check("fpu_funct7", fpu_funct7, lastF7);
`ifdef FPU_ISSUE_PERF_EN
    check("perf_ops", perf_ops, mOps);
    check("perf_stall", perf_stall, mStall);
    if (acc && mOps != 32'hFFFFFFFF) mOps++;
    if (req_valid && !expReady && mStall != 32'hFFFFFFFF) mStall++;
`endif
    if (resp_valid && resp_ready) begin
      popTags.push_back(resp_tag);
      popRes.push_back(resp_result);
    end
    if (req_valid && req_ready) dutAccepts++;
    if (fifoQ.size() != 0 && resp_ready) begin
      e = fifoQ.pop_front();
      mFflags = (fflags_clr ? 5'b0 : mFflags) | e.fl;
    end else if (fflags_clr) begin
      mFflags = 5'b0;
    end
    if (inflight.size() != 0 && inflight[0].due == cyc) begin
      e = inflight.pop_front();
      if (!flush) fifoQ.push_back(e);
    end
    if (flush) begin
      inflight.delete();
      fifoQ.delete();
    end
    if (acc) begin
      e.due = cyc + LAT;
      e.tag = req_tag;
      if (sup) begin
        r     = fpuModel(req_funct7, req_fp1, req_fp2);
        e.res = r[31:0];
        e.fl  = toFflags(r[36:32]);
      end else begin
        e.res = 32'h7FC00000;
        e.fl  = 5'b10000;
      end
      inflight.push_back(e);
    end
    cyc++;
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    req_valid = 0; resp_ready = 0; flush = 0; fflags_clr = 0;
    #1;
    check("rst_req_ready", req_ready, 1'b0);
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_resp_result", resp_result, 32'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_fflags", fflags, 5'b0);
    check("rst_fpu_funct7", fpu_funct7, 7'h0);
    check("rst_fpu_fp1", fpu_fp1, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    inflight.delete();
    fifoQ.delete();
    mFflags = 0; lastFp1 = 0; lastFp2 = 0; lastFrm = 0; lastF7 = 0;
`ifdef FPU_ISSUE_PERF_EN
    mOps = 0; mStall = 0;
`endif
  endtask

  task automatic idle(input int n, input logic rr);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, 7'h0, 32'h0, 32'h0, 3'b0, '0, rr, 1'b0, 1'b0);
      checkOutput();
    end
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 0; req_fp1 = 0; req_fp2 = 0; req_frm = 0; req_funct7 = 0; req_tag = 0;
    resp_ready = 0; flush = 0; fflags_clr = 0;
    cyc = 0; total = 0; bad = 0; dutAccepts = 0;

    //     v  f7   a             b             tag clr rdy rv res           fl        tag ff        busy f7
    addRow(1, ADD, 32'h3F800000, 32'h40000000, 3,  0,  1,  0, 32'h0,        5'b00000, 0,  5'b00000, 0,  ADD);
    addRow(0, 0,   0,            0,            0,  0,  1,  0, 32'h0,        5'b00000, 0,  5'b00000, 1,  ADD);
    addRow(0, 0,   0,            0,            0,  0,  1,  0, 32'h0,        5'b00000, 0,  5'b00000, 1,  ADD);
    addRow(0, 0,   0,            0,            0,  0,  1,  1, 32'h40400000, 5'b00000, 3,  5'b00000, 1,  ADD);
    addRow(0, 0,   0,            0,            0,  0,  1,  0, 32'h0,        5'b00000, 0,  5'b00000, 0,  ADD);
    addRow(1, ADD, 32'h7F800000, 32'hFF800000, 4,  0,  1,  0, 32'h0,        5'b00000, 0,  5'b00000, 0,  ADD);
    addRow(0, 0,   0,            0,            0,  0,  1,  0, 32'h0,        5'b00000, 0,  5'b00000, 1,  ADD);
    addRow(0, 0,   0,            0,            0,  0,  1,  0, 32'h0,        5'b00000, 0,  5'b00000, 1,  ADD);
    addRow(0, 0,   0,            0,            0,  0,  1,  1, 32'h7FC00000, 5'b10000, 4,  5'b00000, 1,  ADD);
    addRow(0, 0,   0,            0,            0,  0,  1,  0, 32'h0,        5'b00000, 0,  5'b10000, 0,  ADD);
    addRow(1, ADD, 32'h3F800000, 32'h40000000, 5,  0,  1,  0, 32'h0,        5'b00000, 0,  5'b10000, 0,  ADD);
    addRow(0, 0,   0,            0,            0,  0,  1,  0, 32'h0,        5'b00000, 0,  5'b10000, 1,  ADD);
    addRow(0, 0,   0,            0,            0,  0,  1,  0, 32'h0,        5'b00000, 0,  5'b10000, 1,  ADD);
    addRow(0, 0,   0,            0,            0,  1,  1,  1, 32'h40400000, 5'b00000, 5,  5'b10000, 1,  ADD);
    addRow(0, 0,   0,            0,            0,  0,  1,  0, 32'h0,        5'b00000, 0,  5'b00000, 0,  ADD);
    addRow(1, UNS, 32'h12345678, 32'h9ABCDEF0, 7,  0,  1,  0, 32'h0,        5'b00000, 0,  5'b00000, 0,  ADD);
    addRow(0, 0,   0,            0,            0,  0,  1,  0, 32'h0,        5'b00000, 0,  5'b00000, 1,  ADD);
    addRow(0, 0,   0,            0,            0,  0,  1,  0, 32'h0,        5'b00000, 0,  5'b00000, 1,  ADD);
    addRow(0, 0,   0,            0,            0,  0,  1,  1, 32'h7FC00000, 5'b10000, 7,  5'b00000, 1,  ADD);
    addRow(0, 0,   0,            0,            0,  0,  1,  0, 32'h0,        5'b00000, 0,  5'b10000, 0,  ADD);

    doReset();

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].v, vecs[i].f7, vecs[i].a, vecs[i].b, 3'b000, vecs[i].tag,
                    vecs[i].rr, vecs[i].fl, vecs[i].clr);
      check("vec_req_ready", req_ready, vecs[i].eReady);
      check("vec_resp_valid", resp_valid, vecs[i].eRv);
      if (vecs[i].eRv) begin
        check("vec_resp_result", resp_result, vecs[i].eRes);
        check("vec_resp_flags", resp_flags, vecs[i].eFl);
        check("vec_resp_tag", resp_tag, vecs[i].eTag);
      end
      check("vec_fflags", fflags, vecs[i].eFf);
      check("vec_busy", busy, vecs[i].eBusy);
      check("vec_fpu_funct7", fpu_funct7, vecs[i].eF7);
      checkOutput();
    end

    // Back-to-back MULs return on consecutive cycles in tag order
    popTags.delete(); popRes.delete();
    for (int t = 1; t <= 3; t++) begin
      applyStimulus(1'b1, MUL, 32'h40000000, 32'h40400000, 3'b001, TW'(t), 1'b1, 1'b0, 1'b0);
      checkOutput();
    end
    idle(6, 1'b1);
    check("b2b_count", popTags.size(), 3);
    for (int i = 0; i < popTags.size() && i < 3; i++) begin
      check("b2b_tag", popTags[i], i + 1);
      check("b2b_result", popRes[i], 32'h40C00000);
    end

    // Backpressure: only RESP_DEPTH ops fit while the consumer stalls
    popTags.delete(); popRes.delete(); dutAccepts = 0;
    for (int t = 10; t < 16; t++) begin
      applyStimulus(1'b1, ADD, $urandom, $urandom, 3'b010, TW'(t), 1'b0, 1'b0, 1'b0);
      checkOutput();
    end
    check("bp_accepted", dutAccepts, 4);
    idle(8, 1'b1);
    check("bp_pop_count", popTags.size(), 4);
    for (int i = 0; i < popTags.size() && i < 4; i++) check("bp_tag", popTags[i], 10 + i);
    applyStimulus(1'b1, SUB, 32'h11111111, 32'h22222222, 3'b000, 16, 1'b1, 1'b0, 1'b0);
    check("bp_resume_ready", req_ready, 1'b1);
    checkOutput();
    idle(5, 1'b1);

    // Flush with two ops in flight and one buffered
    popTags.delete(); popRes.delete();
    for (int t = 20; t < 23; t++) begin
      applyStimulus(1'b1, MUL, $urandom, $urandom, 3'b000, TW'(t), 1'b0, 1'b0, 1'b0);
      checkOutput();
    end
    applyStimulus(1'b1, ADD, 32'h3F800000, 32'h3F800000, 3'b000, 23, 1'b0, 1'b1, 1'b0);
    check("flush_cycle_ready", req_ready, 1'b0);
    checkOutput();
    applyStimulus(1'b0, 7'h0, 32'h0, 32'h0, 3'b000, 0, 1'b1, 1'b0, 1'b0);
    check("flush_resp_valid", resp_valid, 1'b0);
    check("flush_busy", busy, 1'b0);
    checkOutput();
    idle(4, 1'b1);
    check("flush_no_resp", popTags.size(), 0);
    applyStimulus(1'b1, ADD, 32'h3F800000, 32'h40000000, 3'b000, 24, 1'b1, 1'b0, 1'b0);
    checkOutput();
    idle(5, 1'b1);
    check("post_flush_count", popTags.size(), 1);
    if (popTags.size() == 1) begin
      check("post_flush_tag", popTags[0], 24);
      check("post_flush_result", popRes[0], 32'h40400000);
    end

    // Random traffic with a reset dropped in mid-stream
    for (int i = 0; i < 500; i++) begin
      logic [6:0] f7;
      logic [2:0] sel;
      if (i == 250) doReset();
      sel = 3'($urandom_range(0, 5));
      case (sel)
        3'd0: f7 = ADD;
        3'd1: f7 = SUB;
        3'd2, 3'd3: f7 = MUL;
        3'd4: f7 = UNS;
        default: f7 = 7'h7F;
      endcase
      applyStimulus($urandom_range(0, 3) != 0, f7, $urandom, $urandom, 3'($urandom_range(0, 7)),
                    TW'($urandom), $urandom_range(0, 2) != 0, $urandom_range(0, 29) == 0,
                    $urandom_range(0, 14) == 0);
      checkOutput();
    end
    idle(8, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
